// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: address split, widths, state encoding.
package fetch_pkg;

    localparam int unsigned INST_W      = 32;
    localparam int unsigned BUS_AW      = 16;
    localparam int unsigned WORD_AW     = BUS_AW - 2;
    localparam int unsigned PC_AW       = 17;
    // pc_addr[16:14] != 0 routes a fetch off-PRAM onto the bus responder
    localparam int unsigned REGION_HI   = 16;
    localparam int unsigned REGION_LO   = 14;

    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_bus_responder.sv
// Serves off-PRAM instruction fetches from slow external memory through a
// one-word line buffer, stalling the fetch stage while a transaction is open.
module fetch_bus_responder
    import fetch_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter int unsigned       CNT_W          = 8,
    parameter logic [INST_W-1:0] NOP_INST       = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_bus_en,
    input  logic [BUS_AW-1:0] f_bus_addr,
    output logic              ext_req,
    output logic [BUS_AW-1:0] ext_addr,
    input  logic [INST_W-1:0] ext_rdata,
    input  logic              ext_ack,
    output logic [INST_W-1:0] bus_inst_data,
    output logic              bus_inst_valid,
    output logic              f_stall,
    output logic              bus_err
);

    // Last WAIT cycle index: the transaction fails after TIMEOUT_CYCLES cycles
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_e       state_q, state_d;
    logic               buf_valid_q, buf_valid_d;
    logic [WORD_AW-1:0] buf_addr_q, buf_addr_d;
    logic [INST_W-1:0]  buf_data_q, buf_data_d;
    logic [WORD_AW-1:0] req_addr_q, req_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               hold_q;

    logic [WORD_AW-1:0] fetch_word;
    logic               misaligned;
    logic               hit;
    logic               abort_now;

    assign fetch_word = f_bus_addr[BUS_AW-1:2];
    assign misaligned = (f_bus_addr[1:0] != 2'b00);
    assign hit        = buf_valid_q && (buf_addr_q == fetch_word);

    // hold_q masks the first cycle after reset release
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            req_addr_q  <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            req_addr_q  <= req_addr_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            hold_q      <= 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        buf_valid_d    = buf_valid_q;
        buf_addr_d     = buf_addr_q;
        buf_data_d     = buf_data_q;
        req_addr_d     = req_addr_q;
        cnt_d          = cnt_q;
        abort_d        = abort_q;
        abort_now      = abort_q;
        ext_req        = 1'b0;
        ext_addr       = '0;
        bus_inst_data  = '0;
        bus_inst_valid = 1'b0;
        f_stall        = 1'b0;
        bus_err        = 1'b0;

        if (!hold_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (f_bus_en) begin
                        if (misaligned) begin
                            f_stall = 1'b1;
                            state_d = ST_ERR;
                        end else if (hit) begin
                            bus_inst_data  = buf_data_q;
                            bus_inst_valid = 1'b1;
                        end else begin
                            f_stall    = 1'b1;
                            req_addr_d = fetch_word;
                            cnt_d      = '0;
                            abort_d    = 1'b0;
                            state_d    = ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    ext_req   = 1'b1;
                    ext_addr  = {req_addr_q, 2'b00};
                    f_stall   = 1'b1;
                    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    // A flush or redirect while waiting means nobody wants this word
                    abort_now = abort_q || !f_bus_en || (fetch_word != req_addr_q);
                    abort_d   = abort_now;
                    if (ext_ack) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q;
                        buf_data_d  = ext_rdata;
                        state_d     = ST_IDLE;
                    end else if (cnt_q >= CNT_LAST) begin
                        buf_valid_d = 1'b0;
                        state_d     = abort_now ? ST_IDLE : ST_ERR;
                    end
                end

                ST_ERR: begin
                    bus_inst_data  = NOP_INST;
                    bus_inst_valid = 1'b1;
                    bus_err        = 1'b1;
                    state_d        = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end

        if (reset) begin
            ext_req        = 1'b0;
            ext_addr       = '0;
            bus_inst_data  = '0;
            bus_inst_valid = 1'b0;
            f_stall        = 1'b0;
            bus_err        = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_bus_responder.sv
// Scenario bench for fetch_bus_responder with a transaction-level buffer model.
module tb_fetch_bus_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TMO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_bus_en;
    logic [15:0] f_bus_addr;
    logic        ext_req;
    logic [15:0] ext_addr;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic [31:0] bus_inst_data;
    logic        bus_inst_valid;
    logic        f_stall;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    // Reference line buffer: what a correct responder would currently hold
    logic        m_valid = 1'b0;
    logic [13:0] m_word  = '0;
    logic [31:0] m_data  = '0;

    logic [51:0] obs;
    logic [51:0] exp_v;

    fetch_bus_responder dut (
        .clk            (clk),
        .reset          (reset),
        .f_bus_en       (f_bus_en),
        .f_bus_addr     (f_bus_addr),
        .ext_req        (ext_req),
        .ext_addr       (ext_addr),
        .ext_rdata      (ext_rdata),
        .ext_ack        (ext_ack),
        .bus_inst_data  (bus_inst_data),
        .bus_inst_valid (bus_inst_valid),
        .f_stall        (f_stall),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    assign obs = {ext_req, ext_addr, bus_inst_data, bus_inst_valid, f_stall, bus_err};

    function automatic logic [51:0] pk(input logic r, input logic [15:0] a, input logic [31:0] d,
                                       input logic v, input logic s, input logic e);
        return {r, a, d, v, s, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; f_bus_en = 1'b1; f_bus_addr = 16'h4000; ext_ack = 1'b0; ext_rdata = '0;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp_v); end
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_release_cycle got=%h exp=%h", obs, exp_v); end
        step();
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL first_miss_issue got=%h exp=%h", obs, exp_v); end
        step();
        ext_ack = 1'b1; ext_rdata = 32'hA5A5_0001;
        @(negedge clk);
        exp_v = pk(1, 16'h4000, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL first_miss_req got=%h exp=%h", obs, exp_v); end
        step();
        ext_ack = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, 32'hA5A5_0001, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL first_miss_deliver got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h1000; m_data = 32'hA5A5_0001;
    endtask

    task automatic test_miss();
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4010;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL miss_issue got=%h exp=%h", obs, exp_v); end
        for (int i = 0; i <= 3; i++) begin
            step();
            if (i == 3) begin ext_ack = 1'b1; ext_rdata = 32'hDEAD_BEEF; end
            @(negedge clk);
            exp_v = pk(1, 16'h4010, 0, 0, 1, 0); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL miss_wait%0d got=%h exp=%h", i, obs, exp_v); end
        end
        step();
        ext_ack = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, 32'hDEAD_BEEF, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL miss_deliver got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h1004; m_data = 32'hDEAD_BEEF;
    endtask

    task automatic test_hit();
        logic [31:0] d;
        step();
        f_bus_addr = 16'h4010;
        @(negedge clk);
        exp_v = pk(0, 0, 32'hDEAD_BEEF, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL repeat_hit got=%h exp=%h", obs, exp_v); end
        step();
        f_bus_addr = 16'h4014;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL next_word_miss got=%h exp=%h", obs, exp_v); end
        d = $urandom;
        step();
        ext_ack = 1'b1; ext_rdata = d;
        @(negedge clk);
        exp_v = pk(1, 16'h4014, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL next_word_req got=%h exp=%h", obs, exp_v); end
        step();
        ext_ack = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, d, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL next_word_deliver got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h1005; m_data = d;
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] d;
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4020;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL tmo_issue got=%h exp=%h", obs, exp_v); end
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            @(negedge clk);
            if (!ext_req) break;
            n++;
        end
        total++;
        if (n !== TMO) begin bad++; $display("FAIL tmo_length got=%0d exp=%0d", n, TMO); end
        exp_v = pk(0, 0, NOP, 1, 0, 1); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL tmo_err got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b0;
        step();
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL tmo_refetch_miss got=%h exp=%h", obs, exp_v); end
        d = $urandom;
        step();
        ext_ack = 1'b1; ext_rdata = d;
        step();
        ext_ack = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, d, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL tmo_refetch_deliver got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h1008; m_data = d;
    endtask

    task automatic test_ack_at_limit();
        int n;
        logic [31:0] d;
        d = $urandom;
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4050;
        n = 0;
        for (int i = 0; i < TMO; i++) begin
            step();
            if (i == TMO - 1) begin ext_ack = 1'b1; ext_rdata = d; end
            @(negedge clk);
            if (ext_req) n++;
        end
        total++;
        if (n !== TMO) begin bad++; $display("FAIL limit_req_cycles got=%0d exp=%0d", n, TMO); end
        step();
        ext_ack = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, d, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL limit_ack_wins got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h1014; m_data = d;
    endtask

    task automatic test_misaligned();
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4002;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL misal_stall got=%h exp=%h", obs, exp_v); end
        step();
        f_bus_en = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, NOP, 1, 0, 1); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL misal_err got=%h exp=%h", obs, exp_v); end
        step();
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL misal_after got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_abort();
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4030;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_issue got=%h exp=%h", obs, exp_v); end
        for (int i = 0; i < 5; i++) begin
            step();
            f_bus_en   = (i == 2);
            f_bus_addr = 16'h4034;
            if (i == 4) begin ext_ack = 1'b1; ext_rdata = 32'h1234_5678; end
            @(negedge clk);
            exp_v = pk(1, 16'h4030, 0, 0, 1, 0); total++;
            if (obs !== exp_v) begin bad++; $display("FAIL abort_wait%0d got=%h exp=%h", i, obs, exp_v); end
        end
        step();
        ext_ack = 1'b0; f_bus_en = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_no_deliver got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h100C; m_data = 32'h1234_5678;
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4030;
        @(negedge clk);
        exp_v = pk(0, 0, 32'h1234_5678, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_later_hit got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_abort_timeout();
        int n;
        logic [31:0] d;
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4040;
        step();
        f_bus_en = 1'b0;
        n = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            @(negedge clk);
            if (!ext_req) break;
            n++;
        end
        total++;
        if (n !== TMO) begin bad++; $display("FAIL abort_tmo_length got=%0d exp=%0d", n, TMO); end
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_tmo_silent got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b0;
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4030;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL abort_tmo_buf_dropped got=%h exp=%h", obs, exp_v); end
        d = $urandom;
        step();
        ext_ack = 1'b1; ext_rdata = d;
        step();
        ext_ack = 1'b0;
        m_valid = 1'b1; m_word = 14'h100C; m_data = d;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d;
        step();
        f_bus_en = 1'b1; f_bus_addr = 16'h4060;
        step();
        @(negedge clk);
        exp_v = pk(1, 16'h4060, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_req got=%h exp=%h", obs, exp_v); end
        step();
        reset = 1'b1;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_outputs got=%h exp=%h", obs, exp_v); end
        step();
        reset = 1'b0; f_bus_addr = 16'h4030;
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_release got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b0;
        step();
        @(negedge clk);
        exp_v = pk(0, 0, 0, 0, 1, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_buf_cleared got=%h exp=%h", obs, exp_v); end
        d = $urandom;
        step();
        ext_ack = 1'b1; ext_rdata = d;
        step();
        ext_ack = 1'b0;
        @(negedge clk);
        exp_v = pk(0, 0, d, 1, 0, 0); total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_refill got=%h exp=%h", obs, exp_v); end
        m_valid = 1'b1; m_word = 14'h100C; m_data = d;
    endtask

    task automatic test_random();
        logic [13:0] w;
        logic [1:0]  lo;
        logic [31:0] d;
        int          dly;
        bit          ab;
        for (int it = 0; it < 150; it++) begin
            step();
            ext_ack = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                // idle cycle with a stray acknowledge that must be ignored
                f_bus_en = 1'b0; ext_ack = 1'b1; ext_rdata = $urandom;
                @(negedge clk);
                exp_v = pk(0, 0, 0, 0, 0, 0); total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rnd_idle it=%0d got=%h exp=%h", it, obs, exp_v); end
                continue;
            end
            w  = 14'h1000 + 14'($urandom_range(0, 7));
            lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            f_bus_en = 1'b1; f_bus_addr = {w, lo};
            @(negedge clk);
            if (lo != 2'b00) begin
                exp_v = pk(0, 0, 0, 0, 1, 0); total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rnd_misal it=%0d got=%h exp=%h", it, obs, exp_v); end
                step();
                f_bus_en = 1'b0;
                @(negedge clk);
                exp_v = pk(0, 0, NOP, 1, 0, 1); total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rnd_misal_err it=%0d got=%h exp=%h", it, obs, exp_v); end
            end else if (m_valid && m_word == w) begin
                exp_v = pk(0, 0, m_data, 1, 0, 0); total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rnd_hit it=%0d got=%h exp=%h", it, obs, exp_v); end
            end else begin
                exp_v = pk(0, 0, 0, 0, 1, 0); total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rnd_miss it=%0d got=%h exp=%h", it, obs, exp_v); end
                dly = $urandom_range(0, 5);
                ab  = ($urandom_range(0, 3) == 0);
                d   = $urandom;
                for (int i = 0; i <= dly; i++) begin
                    step();
                    if (ab) begin
                        f_bus_en   = $urandom_range(0, 1) == 1;
                        f_bus_addr = {w + 14'd1, 2'b00};
                    end
                    if (i == dly) begin ext_ack = 1'b1; ext_rdata = d; end
                    @(negedge clk);
                    exp_v = pk(1, {w, 2'b00}, 0, 0, 1, 0); total++;
                    if (obs !== exp_v) begin bad++; $display("FAIL rnd_wait it=%0d got=%h exp=%h", it, obs, exp_v); end
                end
                m_valid = 1'b1; m_word = w; m_data = d;
                step();
                ext_ack = 1'b0;
                if (ab) begin
                    f_bus_en = 1'b0;
                    @(negedge clk);
                    exp_v = pk(0, 0, 0, 0, 0, 0);
                end else begin
                    @(negedge clk);
                    exp_v = pk(0, 0, d, 1, 0, 0);
                end
                total++;
                if (obs !== exp_v) begin bad++; $display("FAIL rnd_after_ack it=%0d got=%h exp=%h", it, obs, exp_v); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_timeout();
        test_misaligned();
        test_abort();
        test_abort_timeout();
        test_ack_at_limit();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
